disk_ii_head: RTL and testbench
===============================

Name: disk_ii_head

Overview:
- Models the Disk II drive mechanism: the four-phase head stepper and disk rotation.
- Produces the current track number, which is consumed by the track loader to fetch or flush a 13-sector track buffer.
- Also produces the byte address within that buffer, advancing once per byte time.
- Moves nibbles between the track buffer and the CPU-side read/write latches, and sits directly between the IWM/soft-switch decode and the track loader.

Parameters:
TRACK_BYTES, 6656, bytes per track buffer (13 x 512); fd_track_addr wraps at this value
BYTE_CYCLES, 32, ph_en ticks per byte time
MAX_HALFTRACK, 69, highest reachable half-track (track 34.5)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ph_en  in  1  CPU-cycle clock enable; asserted for one clk, never on consecutive clks
phase  in  4  stepper magnet states, phase[0]..phase[3]
motor_on  in  1  drive motor on
cpu_wait_fdd  in  1  track loader busy; freezes rotation
track  out  6  current whole track = halftrack>>1
fd_track_addr  out  14  byte address into the track buffer
fd_data_in  in  8  track buffer read data, one clk latency from fd_track_addr
read_strobe  in  1  one-clk pulse: CPU read of the data latch
data_out  out  8  latch value presented to the CPU
write_mode  in  1  Q7 set: drive is writing
write_strobe  in  1  one-clk pulse: CPU load of a write byte
write_data  in  8  byte to write
fd_data_do  out  8  byte to store in the track buffer
fd_write_disk  out  1  one-clk write pulse to the track buffer

Behaviour:
- Reset values (every output and register cleared):
  - halftrack = 0, track = 0, fd_track_addr = 0, byte_cnt = 0.
  - latch = 0, latch_valid = 0, wbuf = 0, wbuf_full = 0.
  - fd_data_do = 0, fd_write_disk = 0.
- Reset mid-operation aborts any pending write with no fd_write_disk pulse.

Stepper:
- Evaluated on ph_en only, and only when motor_on = 1.
- Even halftrack h, with q = (h/2) mod 4:
  - phase[(q+1)%4] & ~phase[(q+3)%4] -> h+1.
  - phase[(q+3)%4] & ~phase[(q+1)%4] -> h-1.
- Odd halftrack h, with q = ((h-1)/2) mod 4:
  - phase[(q+1)%4] & ~phase[q] -> h+1.
  - phase[q] & ~phase[(q+1)%4] -> h-1.
- Any other phase combination: hold.
- Saturate at 0 and MAX_HALFTRACK; a step past either end is ignored.
- At most one half-track step per ph_en.
- track is registered and updates on the clk after halftrack changes.

Rotation:
- Active when ph_en & motor_on & ~cpu_wait_fdd.
- byte_cnt counts 0..BYTE_CYCLES-1.
- At terminal count: byte_cnt -> 0, and fd_track_addr increments, wrapping TRACK_BYTES-1 -> 0.
- While cpu_wait_fdd or ~motor_on: byte_cnt and fd_track_addr hold.
- A track change does not reset fd_track_addr; rotation position is preserved.
- Load point: the rotating ph_en on which byte_cnt == 1. fd_data_in is valid there because the address was stable for at least 2 clk.

Read path (write_mode = 0):
- At the load point: latch <= fd_data_in, latch_valid <= 1.
- data_out = latch_valid ? latch : {1'b0, latch[6:0]}.
- read_strobe clears latch_valid on the next clk.
- read_strobe and a load on the same clk: the load wins, so latch_valid = 1 with the new byte.

Write path (write_mode = 1):
- write_strobe: wbuf <= write_data, wbuf_full <= 1.
- At the load point with wbuf_full = 1:
  - fd_data_do <= wbuf, and fd_write_disk = 1 for exactly one clk, with fd_track_addr = the current address.
  - wbuf_full <= 0.
- At the load point with wbuf_full = 0: no write; the address still advances.
- write_strobe coincident with a commit: the old wbuf is committed, the new byte is stored, and wbuf_full stays 1.
- The latch is not loaded in write_mode.
- fd_write_disk is never asserted when write_mode = 0.

Test Plan:
- Reset, motor_on = 1, phase pulsed 0001 -> 0010 -> 0100 -> 1000 -> 0001 -> halftrack 0 -> 1,2 -> 3,4 -> 5,6 -> 7,8, so track = 4. Reverse sequence from 0001 at halftrack 0 -> halftrack stays 0.
- Motor on, continuous ph_en, cpu_wait_fdd = 0 -> fd_track_addr increments every 32 ph_en. After 6656 x 32 ph_en, fd_track_addr = 0 again.
- Buffer preloaded with byte i = i[7:0] | 8'h80, read_strobe 2 clk after each load point:
  - data_out = 8'hD5 at addr 0x55 before the strobe.
  - After the strobe, data_out = 8'h55 until the next load.
- write_mode = 1, write_strobe with 8'hFF before the load point at addr 100:
  - fd_write_disk pulses once with fd_data_do = 8'hFF at addr 100.
  - No pulse at addr 101 without a new strobe.
- cpu_wait_fdd held 500 clk mid-byte (byte_cnt = 17) -> fd_track_addr and byte_cnt are unchanged, then resume from 17.
- reset asserted with wbuf_full = 1 and halftrack = 20 -> all outputs = 0 next clk, and no fd_write_disk pulse.

Source files
------------

// File: rtl/disk_ii_head.sv
// disk_ii_head
// Disk II drive mechanism model: four-phase head stepper, disk rotation and
// the nibble path between a 13-sector track buffer and the CPU-side latches.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   ph_en          - CPU-cycle clock enable (single-clk pulse, never back to back)
//   phase[3:0]     - stepper magnet states
//   motor_on       - drive motor running
//   cpu_wait_fdd   - track loader busy; rotation frozen while high
//   track          - current whole track (halftrack >> 1)
//   fd_track_addr  - byte address into the track buffer
//   fd_data_in     - track buffer read data (one clk after fd_track_addr)
//   read_strobe    - CPU read of the data latch (clears the valid bit)
//   data_out       - latch value presented to the CPU
//   write_mode     - drive is writing (Q7)
//   write_strobe   - CPU loads write_data into the write buffer
//   write_data     - byte to write
//   fd_data_do     - byte committed to the track buffer
//   fd_write_disk  - one-clk write pulse to the track buffer
module disk_ii_head #(
  parameter int TRACK_BYTES   = 6656,
  parameter int BYTE_CYCLES   = 32,
  parameter int MAX_HALFTRACK = 69
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ph_en,
  input  logic [3:0]  phase,
  input  logic        motor_on,
  input  logic        cpu_wait_fdd,
  output logic [5:0]  track,
  output logic [13:0] fd_track_addr,
  input  logic [7:0]  fd_data_in,
  input  logic        read_strobe,
  output logic [7:0]  data_out,
  input  logic        write_mode,
  input  logic        write_strobe,
  input  logic [7:0]  write_data,
  output logic [7:0]  fd_data_do,
  output logic        fd_write_disk
);

  localparam int              CNT_W     = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(1);
  localparam logic [13:0]     ADDR_LAST = 14'(TRACK_BYTES - 1);
  localparam logic [6:0]      HT_MAX    = 7'(MAX_HALFTRACK);

  logic [6:0]       halftrack_reg, halftrack_next;
  logic [5:0]       track_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [13:0]      addr_reg, addr_next;
  logic [7:0]       latch_reg;
  logic             latch_valid_reg;
  logic [7:0]       wbuf_reg;
  logic             wbuf_full_reg;
  logic [7:0]       fd_data_do_reg;
  logic             fd_write_disk_reg;

  // Per-quadrant step conditions. For an even halftrack the head sits on
  // magnet q and is pulled by its two neighbours; for an odd halftrack it
  // sits between magnets q and q+1 and moves toward whichever one is alone.
  logic [3:0] even_up, even_dn, odd_up, odd_dn;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_quad
      assign even_up[gi] = phase[(gi + 1) % 4] & ~phase[(gi + 3) % 4];
      assign even_dn[gi] = phase[(gi + 3) % 4] & ~phase[(gi + 1) % 4];
      assign odd_up[gi]  = phase[(gi + 1) % 4] & ~phase[gi];
      assign odd_dn[gi]  = phase[gi] & ~phase[(gi + 1) % 4];
    end
  endgenerate

  // For both parities q = halftrack[2:1].
  logic [1:0] quad;
  logic       step_up, step_dn;

  assign quad    = halftrack_reg[2:1];
  assign step_up = halftrack_reg[0] ? odd_up[quad] : even_up[quad];
  assign step_dn = halftrack_reg[0] ? odd_dn[quad] : even_dn[quad];

  always_comb begin
    halftrack_next = halftrack_reg;
    if (ph_en && motor_on) begin
      if (step_up && (halftrack_reg != HT_MAX))
        halftrack_next = halftrack_reg + 7'd1;
      else if (step_dn && (halftrack_reg != 7'd0))
        halftrack_next = halftrack_reg - 7'd1;
    end
  end

  // Rotation and the load point (the rotating ph_en seen with byte_cnt == 1;
  // the address has then been stable long enough for fd_data_in to be valid).
  logic rotate, byte_end, load_point, commit;

  assign rotate     = ph_en & motor_on & ~cpu_wait_fdd;
  assign byte_end   = (byte_cnt_reg == CNT_LAST);
  assign load_point = rotate & (byte_cnt_reg == CNT_LOAD);
  assign commit     = load_point & write_mode & wbuf_full_reg;

  always_comb begin
    addr_next = addr_reg;
    if (rotate && byte_end)
      addr_next = (addr_reg == ADDR_LAST) ? 14'd0 : addr_reg + 14'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halftrack_reg     <= '0;
      track_reg         <= '0;
      byte_cnt_reg      <= '0;
      addr_reg          <= '0;
      latch_reg         <= '0;
      latch_valid_reg   <= 1'b0;
      wbuf_reg          <= '0;
      wbuf_full_reg     <= 1'b0;
      fd_data_do_reg    <= '0;
      fd_write_disk_reg <= 1'b0;
    end else begin
      halftrack_reg <= halftrack_next;
      track_reg     <= halftrack_reg[6:1];

      if (rotate)
        byte_cnt_reg <= byte_end ? '0 : byte_cnt_reg + CNT_W'(1);
      addr_reg <= addr_next;

      // A fresh load beats a coincident read strobe.
      if (load_point && !write_mode) begin
        latch_reg       <= fd_data_in;
        latch_valid_reg <= 1'b1;
      end else if (read_strobe) begin
        latch_valid_reg <= 1'b0;
      end

      // A strobe on the commit clk refills the buffer after the old byte
      // has been taken, so wbuf_full stays set.
      fd_write_disk_reg <= 1'b0;
      if (commit) begin
        fd_data_do_reg    <= wbuf_reg;
        fd_write_disk_reg <= 1'b1;
      end
      if (write_mode && write_strobe) begin
        wbuf_reg      <= write_data;
        wbuf_full_reg <= 1'b1;
      end else if (commit) begin
        wbuf_full_reg <= 1'b0;
      end
    end
  end

  assign track         = track_reg;
  assign fd_track_addr = addr_reg;
  assign data_out      = latch_valid_reg ? latch_reg : {1'b0, latch_reg[6:0]};
  assign fd_data_do    = fd_data_do_reg;
  assign fd_write_disk = fd_write_disk_reg;

endmodule

// File: tb/tb_disk_ii_head.sv
// Testbench for disk_ii_head: table-driven stepper vectors plus directed
// sequences for rotation, read latch, write commit, loader stall and reset.
// A second instance with a tiny track/byte size exercises the address wrap.
module tb_disk_ii_head;

  logic        clk = 1'b0;
  logic        reset;
  logic        ph_en;
  logic [3:0]  phase;
  logic        motor_on;
  logic        cpu_wait_fdd;
  logic [5:0]  track;
  logic [13:0] fd_track_addr;
  logic [7:0]  fd_data_in = 8'h00;
  logic        read_strobe;
  logic [7:0]  data_out;
  logic        write_mode;
  logic        write_strobe;
  logic [7:0]  write_data;
  logic [7:0]  fd_data_do;
  logic        fd_write_disk;

  logic [5:0]  w_track;
  logic [13:0] w_addr;
  logic [7:0]  w_data_out;
  logic [7:0]  w_data_do;
  logic        w_write_disk;

  disk_ii_head dut (
    .clk(clk), .reset(reset), .ph_en(ph_en), .phase(phase),
    .motor_on(motor_on), .cpu_wait_fdd(cpu_wait_fdd), .track(track),
    .fd_track_addr(fd_track_addr), .fd_data_in(fd_data_in),
    .read_strobe(read_strobe), .data_out(data_out), .write_mode(write_mode),
    .write_strobe(write_strobe), .write_data(write_data),
    .fd_data_do(fd_data_do), .fd_write_disk(fd_write_disk)
  );

  disk_ii_head #(.TRACK_BYTES(6), .BYTE_CYCLES(4), .MAX_HALFTRACK(69)) dut_w (
    .clk(clk), .reset(reset), .ph_en(ph_en), .phase(phase),
    .motor_on(motor_on), .cpu_wait_fdd(cpu_wait_fdd), .track(w_track),
    .fd_track_addr(w_addr), .fd_data_in(fd_data_in),
    .read_strobe(read_strobe), .data_out(w_data_out), .write_mode(write_mode),
    .write_strobe(write_strobe), .write_data(write_data),
    .fd_data_do(w_data_do), .fd_write_disk(w_write_disk)
  );

  always #5 clk = ~clk;

  // Track buffer model: byte i holds i[7:0] | 8'h80, one clk read latency.
  always @(posedge clk) fd_data_in <= {1'b1, fd_track_addr[6:0]};

  // Write pulse monitor (reads the values held during the pulse clk).
  int          wr_cnt = 0;
  int          bad_wr = 0;
  logic [13:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  always @(posedge clk) begin
    if (fd_write_disk) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = fd_track_addr;
      wr_data = fd_data_do;
      if (!write_mode) bad_wr = bad_wr + 1;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_rot = 0;   // rotating ph_en pulses since the last reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s = %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One ph_en pulse followed by an idle clk; strobes last one clk.
  task automatic ph_pulse();
    ph_en = 1'b1;
    if (motor_on && !cpu_wait_fdd) n_rot++;
    @(negedge clk);
    ph_en = 1'b0;
    read_strobe = 1'b0;
    write_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic advance(input int target);
    int guard = 0;
    while (n_rot < target && guard < 20000) begin
      ph_pulse();
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_rot = 0;
  endtask

  task automatic rd_strobe();
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask

  task automatic wr_strobe(input logic [7:0] d);
    write_strobe = 1'b1;
    write_data = d;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  typedef struct {
    logic [3:0] ph;
    logic       motor;
    logic [5:0] exp_track;
  } step_vec_t;

  step_vec_t steps[22];

  initial begin
    int saved;

    steps[0]  = '{4'b0001, 1'b1, 6'd0};  // h0 hold
    steps[1]  = '{4'b0010, 1'b1, 6'd0};  // h1
    steps[2]  = '{4'b0010, 1'b1, 6'd1};  // h2
    steps[3]  = '{4'b0010, 1'b1, 6'd1};  // h2 hold
    steps[4]  = '{4'b0100, 1'b1, 6'd1};  // h3
    steps[5]  = '{4'b0100, 1'b1, 6'd2};  // h4
    steps[6]  = '{4'b1000, 1'b1, 6'd2};  // h5
    steps[7]  = '{4'b1000, 1'b1, 6'd3};  // h6
    steps[8]  = '{4'b0001, 1'b1, 6'd3};  // h7
    steps[9]  = '{4'b0001, 1'b1, 6'd4};  // h8
    steps[10] = '{4'b0001, 1'b1, 6'd4};  // h8 hold
    steps[11] = '{4'b1000, 1'b1, 6'd3};  // h7
    steps[12] = '{4'b1000, 1'b1, 6'd3};  // h6
    steps[13] = '{4'b0100, 1'b1, 6'd2};  // h5
    steps[14] = '{4'b0100, 1'b1, 6'd2};  // h4
    steps[15] = '{4'b0010, 1'b1, 6'd1};  // h3
    steps[16] = '{4'b0010, 1'b1, 6'd1};  // h2
    steps[17] = '{4'b0001, 1'b1, 6'd0};  // h1
    steps[18] = '{4'b0001, 1'b1, 6'd0};  // h0
    steps[19] = '{4'b1000, 1'b1, 6'd0};  // below 0 ignored
    steps[20] = '{4'b0010, 1'b0, 6'd0};  // motor off: hold
    steps[21] = '{4'b0010, 1'b0, 6'd0};  // motor off: hold

    reset = 1'b1; ph_en = 1'b0; phase = 4'b0000; motor_on = 1'b0;
    cpu_wait_fdd = 1'b0; read_strobe = 1'b0; write_mode = 1'b0;
    write_strobe = 1'b0; write_data = 8'h00;
    @(negedge clk);
    do_reset();

    chk("reset_track", track, 0);
    chk("reset_addr", fd_track_addr, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_fd_data_do", fd_data_do, 0);
    chk("reset_fd_write_disk", fd_write_disk, 0);

    // Stepper vectors
    for (int i = 0; i < 22; i++) begin
      phase = steps[i].ph;
      motor_on = steps[i].motor;
      ph_pulse();
      chk($sformatf("step%0d_track", i), track, steps[i].exp_track);
    end

    // Rotation
    phase = 4'b0000;
    motor_on = 1'b1;
    do_reset();
    advance(23);
    chk("rot23_addr", fd_track_addr, 0);
    chk("wrap_inst_addr_5", w_addr, 5);
    advance(24);
    chk("wrap_inst_addr_0", w_addr, 0);
    advance(31);
    chk("rot31_addr", fd_track_addr, 0);
    advance(32);
    chk("rot32_addr", fd_track_addr, 1);
    chk("wrap_inst_addr_2", w_addr, 2);

    // Read path
    advance(32'h55 * 32 + 1);
    chk("latch_prev_byte", data_out, 8'hD4);
    advance(32'h55 * 32 + 2);
    chk("addr_55", fd_track_addr, 14'h55);
    chk("latch_d5", data_out, 8'hD5);
    rd_strobe();
    chk("latch_after_strobe", data_out, 8'h55);
    advance(32'h56 * 32 + 1);
    chk("latch_held_to_next_load", data_out, 8'h55);
    read_strobe = 1'b1;   // coincident with the load point: load wins
    ph_pulse();
    chk("load_beats_strobe", data_out, 8'hD6);
    rd_strobe();
    chk("latch_56_cleared", data_out, 8'h56);

    // Write path
    advance(100 * 32);
    chk("latch_before_write", data_out, 8'hE3);
    write_mode = 1'b1;
    wr_strobe(8'hFF);
    advance(100 * 32 + 2);
    chk("write_count_1", wr_cnt, 1);
    chk("write_addr_100", wr_addr, 100);
    chk("write_data_ff", wr_data, 8'hFF);
    advance(101 * 32 + 2);
    chk("no_write_at_101", wr_cnt, 1);
    chk("latch_frozen_in_write", data_out, 8'hE3);
    wr_strobe(8'h11);
    advance(102 * 32 + 1);
    write_strobe = 1'b1;  // coincident with the commit
    write_data = 8'h22;
    ph_pulse();
    chk("write_count_2", wr_cnt, 2);
    chk("write_addr_102", wr_addr, 102);
    chk("write_data_11", wr_data, 8'h11);
    advance(103 * 32 + 2);
    chk("write_count_3", wr_cnt, 3);
    chk("write_addr_103", wr_addr, 103);
    chk("write_data_22", wr_data, 8'h22);

    // Loader stall mid-byte
    advance(104 * 32 + 17);
    cpu_wait_fdd = 1'b1;
    for (int i = 0; i < 250; i++) ph_pulse();
    cpu_wait_fdd = 1'b0;
    chk("stall_addr_held", fd_track_addr, 104);
    advance(104 * 32 + 31);
    chk("resume_addr_104", fd_track_addr, 104);
    advance(104 * 32 + 32);
    chk("resume_addr_105", fd_track_addr, 105);

    // Step to halftrack 20, then reset with a write pending at the load point
    for (int k = 0; k < 10; k++) begin
      phase = 4'(1 << ((k + 1) % 4));
      ph_pulse();
      ph_pulse();
    end
    phase = 4'b0000;
    chk("track_10", track, 10);
    while ((n_rot % 32) != 1) ph_pulse();
    wr_strobe(8'h5A);
    saved = wr_cnt;
    reset = 1'b1;
    ph_en = 1'b1;
    @(negedge clk);
    ph_en = 1'b0;
    chk("midreset_track", track, 0);
    chk("midreset_addr", fd_track_addr, 0);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_fd_data_do", fd_data_do, 0);
    chk("midreset_fd_write_disk", fd_write_disk, 0);
    @(negedge clk);
    reset = 1'b0;
    n_rot = 0;
    advance(40);
    chk("midreset_no_commit", wr_cnt, saved);
    chk("no_write_in_read_mode", bad_wr, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
